// File: rtl/board_if.sv
// Bus between the falling-piece controller / renderer and the board store.
// Port names on the bus are kept identical to the board_store pin list.
interface board_if #(
   parameter int COLS = 10
);
   logic            lock;
   logic [4:0]      sq_1_col;
   logic [4:0]      sq_2_col;
   logic [4:0]      sq_3_col;
   logic [4:0]      sq_4_col;
   logic [4:0]      sq_1_row;
   logic [4:0]      sq_2_row;
   logic [4:0]      sq_3_row;
   logic [4:0]      sq_4_row;
   logic [4:0]      rd_row;
   logic [COLS-1:0] rd_data;
   logic            busy;
   logic            clr_done;
   logic [7:0]      lines;
   logic            top_out;

   modport master (
      output lock, sq_1_col, sq_2_col, sq_3_col, sq_4_col,
             sq_1_row, sq_2_row, sq_3_row, sq_4_row, rd_row,
      input  rd_data, busy, clr_done, lines, top_out
   );

   modport slave (
      input  lock, sq_1_col, sq_2_col, sq_3_col, sq_4_col,
             sq_1_row, sq_2_row, sq_3_row, sq_4_row, rd_row,
      output rd_data, busy, clr_done, lines, top_out
   );
endinterface

// File: rtl/board_store.sv
// Playfield occupancy grid: latches a landed piece, clears full rows, serves renderer reads.
// Optional feature macro: BOARD_LINE_COUNT_EN enables the cleared-lines counter.
module board_store #(
   parameter int COLS = 10,
   parameter int ROWS = 20
) (
   input logic    pclk,
   input logic    rst,
   board_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_SCAN  = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [5:0]      COLS_W   = 6'(COLS);
   localparam logic [5:0]      ROWS_W   = 6'(ROWS);
   localparam logic [4:0]      LAST_ROW = 5'(ROWS - 1);
   localparam logic [COLS-1:0] ONE_COL  = {{(COLS-1){1'b0}}, 1'b1};

   state_t          state_q, state_d;
   logic [4:0]      col_q [4];
   logic [4:0]      col_d [4];
   logic [4:0]      row_q [4];
   logic [4:0]      row_d [4];
   logic [4:0]      r_q, r_d;
   logic [4:0]      p_q, p_d;
   logic [COLS-1:0] grid_q [ROWS];
   logic [COLS-1:0] grid_d [ROWS];
   logic            top_out_q, top_out_d;
   logic            busy_q, busy_d;
   logic            clr_done_q, clr_done_d;
   logic [COLS-1:0] rd_data_q;

   logic [4:0]      sq_col_s [4];
   logic [4:0]      sq_row_s [4];
   logic [3:0]      sq_ok_s;
   logic [COLS-1:0] row_at_r_s;
   logic [COLS-1:0] row_above_s;
   logic [COLS-1:0] rd_sel_s;
   logic            row_full_s;

   assign sq_col_s[0] = bus.sq_1_col;
   assign sq_col_s[1] = bus.sq_2_col;
   assign sq_col_s[2] = bus.sq_3_col;
   assign sq_col_s[3] = bus.sq_4_col;
   assign sq_row_s[0] = bus.sq_1_row;
   assign sq_row_s[1] = bus.sq_2_row;
   assign sq_row_s[2] = bus.sq_3_row;
   assign sq_row_s[3] = bus.sq_4_row;

   // Range check of the captured squares; anything off the board is dropped.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         sq_ok_s[k] = ({1'b0, col_q[k]} < COLS_W) && ({1'b0, row_q[k]} < ROWS_W);
      end
   end

   // Row multiplexers: scan row, row above the shift pointer, renderer row.
   always_comb begin
      row_at_r_s  = '0;
      row_above_s = '0;
      rd_sel_s    = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (r_q == 5'(i)) begin
            row_at_r_s = grid_q[i];
         end else begin
            row_at_r_s = row_at_r_s;
         end
         if (bus.rd_row == 5'(i)) begin
            rd_sel_s = grid_q[i];
         end else begin
            rd_sel_s = rd_sel_s;
         end
      end
      // Pointer 0 leaves row_above_s at zero, which is exactly the top-row clear.
      for (int i = 1; i < ROWS; i++) begin
         if (p_q == 5'(i)) begin
            row_above_s = grid_q[i-1];
         end else begin
            row_above_s = row_above_s;
         end
      end
   end

   assign row_full_s = (row_at_r_s == {COLS{1'b1}});

   // State register.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.lock) begin
               state_d = S_WRITE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: state_d = S_SCAN;
         S_SCAN: begin
            if (row_full_s) begin
               state_d = S_SHIFT;
            end else if (r_q == 5'd0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SCAN;
            end
         end
         S_SHIFT: begin
            if (p_q == 5'd0) begin
               state_d = S_SCAN;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic, decoded from the next state so the flops line up with it.
   always_comb begin
      busy_d     = (state_d == S_WRITE) || (state_d == S_SCAN) || (state_d == S_SHIFT);
      clr_done_d = (state_d == S_DONE);
   end

   // Datapath next-state: coordinate capture, grid write, scan and shift pointers.
   always_comb begin
      col_d     = col_q;
      row_d     = row_q;
      r_d       = r_q;
      p_d       = p_q;
      grid_d    = grid_q;
      top_out_d = top_out_q;
      case (state_q)
         S_IDLE: begin
            if (bus.lock) begin
               col_d = sq_col_s;
               row_d = sq_row_s;
            end else begin
               col_d = col_q;
            end
         end
         S_WRITE: begin
            for (int k = 0; k < 4; k++) begin
               if (sq_ok_s[k]) begin
                  for (int i = 0; i < ROWS; i++) begin
                     if (row_q[k] == 5'(i)) begin
                        grid_d[i] = grid_d[i] | (ONE_COL << col_q[k]);
                     end else begin
                        grid_d[i] = grid_d[i];
                     end
                  end
                  if (row_q[k] == 5'd0) begin
                     top_out_d = 1'b1;
                  end else begin
                     top_out_d = top_out_d;
                  end
               end else begin
                  top_out_d = top_out_d;
               end
            end
            r_d = LAST_ROW;
         end
         S_SCAN: begin
            // r is left alone on a hit so the row that drops in gets rechecked.
            if (row_full_s) begin
               p_d = r_q;
            end else if (r_q != 5'd0) begin
               r_d = r_q - 5'd1;
            end else begin
               r_d = r_q;
            end
         end
         S_SHIFT: begin
            for (int i = 0; i < ROWS; i++) begin
               if (p_q == 5'(i)) begin
                  grid_d[i] = row_above_s;
               end else begin
                  grid_d[i] = grid_q[i];
               end
            end
            if (p_q != 5'd0) begin
               p_d = p_q - 5'd1;
            end else begin
               p_d = p_q;
            end
         end
         default: begin
            p_d = p_q;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge pclk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            col_q[k] <= 5'd0;
            row_q[k] <= 5'd0;
         end
         for (int i = 0; i < ROWS; i++) begin
            grid_q[i] <= '0;
         end
         r_q        <= 5'd0;
         p_q        <= 5'd0;
         top_out_q  <= 1'b0;
         busy_q     <= 1'b0;
         clr_done_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         grid_q     <= grid_d;
         r_q        <= r_d;
         p_q        <= p_d;
         top_out_q  <= top_out_d;
         busy_q     <= busy_d;
         clr_done_q <= clr_done_d;
         rd_data_q  <= rd_sel_s;
      end
   end

`ifdef BOARD_LINE_COUNT_EN
   logic [7:0] lines_q, lines_d;

   // Saturating count of cleared rows.
   always_comb begin
      if ((state_q == S_SCAN) && row_full_s && (lines_q != 8'hFF)) begin
         lines_d = lines_q + 8'd1;
      end else begin
         lines_d = lines_q;
      end
   end

   // Line counter register.
   always_ff @(posedge pclk) begin
      if (rst) begin
         lines_q <= 8'd0;
      end else begin
         lines_q <= lines_d;
      end
   end

   assign bus.lines = lines_q;
`else
   assign bus.lines = 8'h00;
`endif

   assign bus.rd_data  = rd_data_q;
   assign bus.busy     = busy_q;
   assign bus.clr_done = clr_done_q;
   assign bus.top_out  = top_out_q;
endmodule
